// File: rtl/sid_pkg.sv
// ----------------------------------------------------------------------------
// sid : shared types for the SID bus front end and core.
//   phase_t  : one-hot strobe vector, indexed by phase_e
//   phase_e  : strobe index constants PHI1_PHI2, PHI2, PHI2_PHI1, PHI1
//   reg8_t   : 8-bit register / data byte
//   bus_i_t  : per-PHI2-cycle bus snapshot {addr, data, we, oe, res}
// ----------------------------------------------------------------------------
package sid;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   typedef logic [DATA_W-1:0] reg8_t;

   typedef logic [3:0] phase_t;

   typedef enum logic [1:0] {
      PHI1_PHI2 = 2'd0,
      PHI2      = 2'd1,
      PHI2_PHI1 = 2'd2,
      PHI1      = 2'd3
   } phase_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      reg8_t             data;
      logic              we;
      logic              oe;
      logic              res;
   } bus_i_t;

   // One-hot strobe vector with only the bit for phase p set.
   function automatic phase_t phase_strobe(phase_e p);
      phase_t v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/sid_pad_sync.sv
// ----------------------------------------------------------------------------
// sid_pad_sync : single-bit multi-flop synchroniser for a pad input.
//   clk    in  system clock
//   rst_n  in  async active-low reset; chain clears to RESET_VAL
//   d      in  asynchronous pad level
//   q      out level synchronised into clk (STAGES flops of latency)
// ----------------------------------------------------------------------------
module sid_pad_sync #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_reg <= {STAGES{RESET_VAL}};
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], d};
      end
   end

   assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/sid_bus_if.sv
// ----------------------------------------------------------------------------
// sid_bus_if : 6510 bus pin front end for sid_core.
//   clk          in   system clock (>= 16x PHI2)
//   rst_n        in   async active-low reset
//   phi2_i       in   PHI2 pad
//   res_n_i      in   RES pad, active low
//   cs_n_i       in   CS pad, active low
//   rw_i         in   R/W pad, 1 = read
//   addr_i       in   A4..A0 pads
//   data_i       in   D7..D0 pads, input path
//   data_core_i  in   read data from sid_core
//   bus_o        out  bus snapshot, updated once per PHI2 cycle
//   cs_o         out  registered chip select, active high
//   phase_o      out  one-hot phase strobes, at most one per clk
//   data_o       out  D7..D0 pads, output path
//   data_oe      out  pad output enable
//   phi2_lost_o  out  PHI2 watchdog flag
// ----------------------------------------------------------------------------
module sid_bus_if
   import sid::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_DLY  = 6,
   parameter int TIMEOUT     = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              phi2_i,
   input  logic              res_n_i,
   input  logic              cs_n_i,
   input  logic              rw_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  reg8_t             data_i,
   input  reg8_t             data_core_i,
   output bus_i_t            bus_o,
   output logic              cs_o,
   output phase_t            phase_o,
   output reg8_t             data_o,
   output logic              data_oe,
   output logic              phi2_lost_o
);

   localparam int CNT_W = (SAMPLE_DLY < 1) ? 1 : $clog2(SAMPLE_DLY + 1);

   // FALL_PEND: a fall arrived while the PHI2 strobe is still owed or being
   // emitted; PHI2_PHI1 is deferred so the two strobes never coincide.
   typedef enum logic [2:0] {
      WAIT_RISE,
      HIGH,
      SAMPLED,
      FALL_PEND,
      LOW
   } state_t;

   // ------------------------------------------------------------------
   // Pad synchronisers
   // ------------------------------------------------------------------
   logic              phi2_s;
   logic              cs_n_s;
   logic              rw_s;
   logic              res_n_s;
   logic [ADDR_W-1:0] addr_s;
   reg8_t             data_s;

   sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_phi2 (
      .clk(clk), .rst_n(rst_n), .d(phi2_i), .q(phi2_s));
   sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
      .clk(clk), .rst_n(rst_n), .d(cs_n_i), .q(cs_n_s));
   sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rw (
      .clk(clk), .rst_n(rst_n), .d(rw_i), .q(rw_s));
   sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_res_n (
      .clk(clk), .rst_n(rst_n), .d(res_n_i), .q(res_n_s));

   genvar gi;
   generate
      for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_sync
         sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (
            .clk(clk), .rst_n(rst_n), .d(addr_i[gi]), .q(addr_s[gi]));
      end
      for (gi = 0; gi < DATA_W; gi++) begin : g_data_sync
         sid_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync (
            .clk(clk), .rst_n(rst_n), .d(data_i[gi]), .q(data_s[gi]));
      end
   endgenerate

   // ------------------------------------------------------------------
   // Edge detect and watchdog
   // ------------------------------------------------------------------
   logic       phi2_d_reg;
   logic       rise;
   logic       fall;
   logic [6:0] wd_cnt_reg;
   logic       timeout;
   logic       lost_reg;

   assign rise = phi2_s & ~phi2_d_reg;
   assign fall = ~phi2_s & phi2_d_reg;

   // Fires exactly once per stall: the counter saturates past TIMEOUT-1.
   assign timeout = ~(rise | fall) && (wd_cnt_reg == 7'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi2_d_reg <= 1'b0;
         wd_cnt_reg <= '0;
         lost_reg   <= 1'b1;
      end else begin
         phi2_d_reg <= phi2_s;
         if (rise | fall) begin
            wd_cnt_reg <= '0;
         end else if (wd_cnt_reg != 7'h7F) begin
            wd_cnt_reg <= wd_cnt_reg + 7'd1;
         end
         if (rise) begin
            lost_reg <= 1'b0;
         end else if (timeout) begin
            lost_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Phase FSM
   // ------------------------------------------------------------------
   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               pend_reg, pend_next;   // PHI2 strobe owed this clk
   phase_t             phase_reg, phase_next;
   logic               sample;
   logic               cnt_done;

   assign cnt_done = (cnt_reg == CNT_W'(SAMPLE_DLY));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pend_next  = 1'b0;
      phase_next = '0;
      sample     = 1'b0;

      if (pend_reg) begin
         phase_next = phase_strobe(PHI2);
      end

      case (state_reg)
         WAIT_RISE: begin
            if (rise) begin
               phase_next = phase_strobe(PHI1_PHI2);
               state_next = HIGH;
               cnt_next   = '0;
            end
         end
         HIGH: begin
            cnt_next = cnt_reg + 1'b1;
            if (fall) begin
               // Short high phase: sample now, strobes follow in order.
               sample     = 1'b1;
               pend_next  = 1'b1;
               state_next = FALL_PEND;
            end else if (cnt_done) begin
               sample     = 1'b1;
               pend_next  = 1'b1;
               state_next = SAMPLED;
            end
         end
         SAMPLED: begin
            if (fall) begin
               if (pend_reg) begin
                  state_next = FALL_PEND;
               end else begin
                  phase_next = phase_strobe(PHI2_PHI1);
                  state_next = LOW;
                  cnt_next   = '0;
               end
            end
         end
         FALL_PEND: begin
            if (!pend_reg) begin
               phase_next = phase_strobe(PHI2_PHI1);
               state_next = LOW;
               cnt_next   = '0;
            end
         end
         LOW: begin
            cnt_next = cnt_reg + 1'b1;
            if (rise) begin
               // Early rise: PHI1 is dropped, the new cycle starts at once.
               phase_next = phase_strobe(PHI1_PHI2);
               state_next = HIGH;
               cnt_next   = '0;
            end else if (cnt_done) begin
               phase_next = phase_strobe(PHI1);
               state_next = WAIT_RISE;
            end
         end
         default: begin
            state_next = WAIT_RISE;
         end
      endcase

      if (timeout) begin
         state_next = WAIT_RISE;
         cnt_next   = '0;
         pend_next  = 1'b0;
         phase_next = '0;
         sample     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= WAIT_RISE;
         cnt_reg   <= '0;
         pend_reg  <= 1'b0;
         phase_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pend_reg  <= pend_next;
         phase_reg <= phase_next;
      end
   end

   // ------------------------------------------------------------------
   // Bus snapshot and data pad
   // ------------------------------------------------------------------
   bus_i_t bus_reg;
   bus_i_t bus_sample;
   logic   cs_reg;
   logic   cs_now;
   reg8_t  dout_reg;
   logic   oe_reg, oe_next;

   always_comb begin
      cs_now          = ~cs_n_s;
      bus_sample      = '0;
      bus_sample.addr = addr_s;
      bus_sample.data = data_s;
      bus_sample.we   = cs_now & ~rw_s;
      bus_sample.oe   = cs_now & rw_s;
      bus_sample.res  = ~res_n_s;
   end

   // Drive only while PHI2 is still high: a short-phase read whose PHI2
   // strobe lands after the fall never turns the pad around.
   always_comb begin
      oe_next = oe_reg;
      if (timeout || fall || bus_reg.res) begin
         oe_next = 1'b0;
      end else if (pend_reg && (state_reg == SAMPLED) && bus_reg.oe) begin
         oe_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_reg     <= '0;
         bus_reg.res <= 1'b1;
         cs_reg      <= 1'b0;
         dout_reg    <= '0;
         oe_reg      <= 1'b0;
      end else begin
         if (sample) begin
            bus_reg <= bus_sample;
            cs_reg  <= cs_now;
         end
         dout_reg <= data_core_i;
         oe_reg   <= oe_next;
      end
   end

   assign bus_o       = bus_reg;
   assign cs_o        = cs_reg;
   assign phase_o     = phase_reg;
   assign data_o      = dout_reg;
   assign data_oe     = oe_reg;
   assign phi2_lost_o = lost_reg;

endmodule
